// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: register-address width and the load-result FIFO entry.
package wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_src;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage : wb_arbiter_pkg

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: ALU/load result inputs, issue scoreboard and regfile write port.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface wb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     alu_valid;
    logic [4:0]               alu_rd_src;
    logic [XLEN-1:0]          alu_data;
    logic                     ld_valid;
    logic                     ld_ready;
    logic [4:0]               ld_rd_src;
    logic [XLEN-1:0]          ld_data;
    logic                     iss_ld;
    logic [4:0]               iss_rd_src;
    logic [31:0]              busy_mask;
    logic                     reg_we;
    logic [4:0]               rd_src;
    logic [XLEN-1:0]          rd;
    logic [$clog2(DEPTH):0]   fifo_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]               rs1_src;
    logic [4:0]               rs2_src;
    logic [XLEN-1:0]          rs1_in;
    logic [XLEN-1:0]          rs2_in;
    logic [XLEN-1:0]          rs1_fwd;
    logic [XLEN-1:0]          rs2_fwd;
`endif

    modport slave (
        input  alu_valid, alu_rd_src, alu_data,
        input  ld_valid, ld_rd_src, ld_data,
        input  iss_ld, iss_rd_src,
`ifdef WB_BYPASS_EN
        input  rs1_src, rs2_src, rs1_in, rs2_in,
        output rs1_fwd, rs2_fwd,
`endif
        output ld_ready, busy_mask, reg_we, rd_src, rd, fifo_cnt
    );

    modport master (
        output alu_valid, alu_rd_src, alu_data,
        output ld_valid, ld_rd_src, ld_data,
        output iss_ld, iss_rd_src,
`ifdef WB_BYPASS_EN
        output rs1_src, rs2_src, rs1_in, rs2_in,
        input  rs1_fwd, rs2_fwd,
`endif
        input  ld_ready, busy_mask, reg_we, rd_src, rd, fifo_cnt
    );

endinterface : wb_arbiter_if

// File: rtl/wb_arbiter_fifo.sv
// Load-result FIFO: DEPTH entries of entry_t, strict order, head read straight from the storage flops.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, power-of-two pointers wrap on overflow.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : wb_fifo

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: ALU has priority, buffered loads drain on idle ALU cycles, plus load scoreboard.
// Optional feature macro: WB_BYPASS_EN (write-port forwarding to rs1/rs2 operands).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_src;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t                  push_entry_s;
    entry_t                  head_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic [$clog2(DEPTH):0]  count_s;

    logic                    reg_we_q, reg_we_d;
    logic [REG_ADDR_W-1:0]   rd_src_q, rd_src_d;
    logic [XLEN-1:0]         rd_q, rd_d;
    logic [31:0]             busy_q, busy_d;

    // Full blocks acceptance even if the head is leaving this cycle.
    assign bus.ld_ready  = !full_s;
    assign push_s        = bus.ld_valid && !full_s;
    assign push_entry_s  = '{rd_src: bus.ld_rd_src, data: bus.ld_data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Writeback source select; x0 loads are consumed without a write.
    always_comb begin
        reg_we_d = 1'b0;
        rd_src_d = rd_src_q;
        rd_d     = rd_q;
        pop_s    = 1'b0;
        if (bus.alu_valid) begin
            reg_we_d = 1'b1;
            rd_src_d = bus.alu_rd_src;
            rd_d     = bus.alu_data;
        end else if (!empty_s) begin
            pop_s = 1'b1;
            if (head_s.rd_src != 5'd0) begin
                reg_we_d = 1'b1;
                rd_src_d = head_s.rd_src;
                rd_d     = head_s.data;
            end else begin
                reg_we_d = 1'b0;
            end
        end else begin
            reg_we_d = 1'b0;
        end
    end

    // Scoreboard update: clear on pop first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (pop_s && (head_s.rd_src != 5'd0)) begin
            busy_d[head_s.rd_src] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (bus.iss_ld && (bus.iss_rd_src != 5'd0)) begin
            busy_d[bus.iss_rd_src] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we_q <= 1'b0;
            rd_src_q <= {REG_ADDR_W{1'b0}};
            rd_q     <= {XLEN{1'b0}};
            busy_q   <= 32'd0;
        end else begin
            reg_we_q <= reg_we_d;
            rd_src_q <= rd_src_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.reg_we    = reg_we_q;
    assign bus.rd_src    = rd_src_q;
    assign bus.rd        = rd_q;
    assign bus.busy_mask = busy_q;
    assign bus.fifo_cnt  = count_s;

`ifdef WB_BYPASS_EN
    // Forward the in-flight regfile write to decode operands.
    always_comb begin
        bus.rs1_fwd = bus.rs1_in;
        bus.rs2_fwd = bus.rs2_in;
        if (reg_we_q && (rd_src_q == bus.rs1_src) && (bus.rs1_src != 5'd0)) begin
            bus.rs1_fwd = rd_q;
        end else begin
            bus.rs1_fwd = bus.rs1_in;
        end
        if (reg_we_q && (rd_src_q == bus.rs2_src) && (bus.rs2_src != 5'd0)) begin
            bus.rs2_fwd = rd_q;
        end else begin
            bus.rs2_fwd = bus.rs2_in;
        end
    end
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   k;

    wb_arbiter_if #(.XLEN(32), .DEPTH(4)) bus ();

    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.alu_valid  = 1'b0;
        bus.alu_rd_src = 5'd0;
        bus.alu_data   = 32'd0;
        bus.ld_valid   = 1'b1;
        bus.ld_rd_src  = 5'd4;
        bus.ld_data    = 32'h1234;
        bus.iss_ld     = 1'b0;
        bus.iss_rd_src = 5'd0;
`ifdef WB_BYPASS_EN
        bus.rs1_src = 5'd0;
        bus.rs2_src = 5'd0;
        bus.rs1_in  = 32'd0;
        bus.rs2_in  = 32'd0;
`endif
        rst_n = 1'b0;

        // 1: reset with a load offered
        cyc();
        cyc();
        check_val("rst_reg_we", 64'(bus.reg_we), 64'd0);
        check_val("rst_busy", 64'(bus.busy_mask), 64'd0);
        check_val("rst_cnt", 64'(bus.fifo_cnt), 64'd0);
        check_val("rst_rd", 64'(bus.rd), 64'd0);
        rst_n = 1'b1;
        bus.ld_valid = 1'b0;
        #1;
        check_val("rst_ld_ready", 64'(bus.ld_ready), 64'd1);

        // 2: ALU write, 1-cycle latency, then hold
        bus.alu_valid  = 1'b1;
        bus.alu_rd_src = 5'd5;
        bus.alu_data   = 32'hDEADBEEF;
        cyc();
        bus.alu_valid = 1'b0;
        check_val("alu_we", 64'(bus.reg_we), 64'd1);
        check_val("alu_rd_src", 64'(bus.rd_src), 64'd5);
        check_val("alu_rd", 64'(bus.rd), 64'hDEADBEEF);
        cyc();
        check_val("idle_we", 64'(bus.reg_we), 64'd0);
        check_val("idle_hold_src", 64'(bus.rd_src), 64'd5);
        check_val("idle_hold_rd", 64'(bus.rd), 64'hDEADBEEF);

        // 3: issue x7, load returns, write 2 cycles after acceptance
        bus.iss_ld     = 1'b1;
        bus.iss_rd_src = 5'd7;
        cyc();
        bus.iss_ld = 1'b0;
        check_val("iss7_busy", 64'(bus.busy_mask), 64'h80);
        bus.ld_valid  = 1'b1;
        bus.ld_rd_src = 5'd7;
        bus.ld_data   = 32'h11;
        cyc();
        bus.ld_valid = 1'b0;
        check_val("ld7_cnt", 64'(bus.fifo_cnt), 64'd1);
        check_val("ld7_we_early", 64'(bus.reg_we), 64'd0);
        check_val("ld7_busy_held", 64'(bus.busy_mask), 64'h80);
        cyc();
        check_val("ld7_we", 64'(bus.reg_we), 64'd1);
        check_val("ld7_src", 64'(bus.rd_src), 64'd7);
        check_val("ld7_rd", 64'(bus.rd), 64'h11);
        check_val("ld7_busy_clr", 64'(bus.busy_mask), 64'd0);
        check_val("ld7_cnt_after", 64'(bus.fifo_cnt), 64'd0);

        // same-register set and clear in one cycle: set wins
        bus.iss_ld     = 1'b1;
        bus.iss_rd_src = 5'd9;
        cyc();
        bus.iss_ld    = 1'b0;
        bus.ld_valid  = 1'b1;
        bus.ld_rd_src = 5'd9;
        bus.ld_data   = 32'h99;
        cyc();
        bus.ld_valid   = 1'b0;
        bus.iss_ld     = 1'b1;
        bus.iss_rd_src = 5'd9;
        cyc();
        bus.iss_ld = 1'b0;
        check_val("setwin_we", 64'(bus.reg_we), 64'd1);
        check_val("setwin_busy", 64'(bus.busy_mask), 64'h200);
        bus.ld_valid  = 1'b1;
        bus.ld_data   = 32'h9A;
        cyc();
        bus.ld_valid = 1'b0;
        cyc();
        check_val("x9_drain_rd", 64'(bus.rd), 64'h9A);
        check_val("x9_drain_busy", 64'(bus.busy_mask), 64'd0);

        // 4: ALU busy every cycle while 5 loads are offered
        k = 0;
        bus.alu_valid  = 1'b1;
        bus.alu_rd_src = 5'd1;
        for (int i = 0; i < 6; i++) begin
            bus.alu_data  = 32'h100 + 32'(i);
            bus.ld_valid  = 1'b1;
            bus.ld_rd_src = 5'(10 + k);
            bus.ld_data   = 32'hA0 + 32'(k);
            #1;
            if (bus.ld_ready) k++;
            cyc();
        end
        bus.ld_rd_src = 5'(10 + k);
        bus.ld_data   = 32'hA0 + 32'(k);
        #1;
        check_val("full_accepts", 64'(k), 64'd4);
        check_val("full_cnt", 64'(bus.fifo_cnt), 64'd4);
        check_val("full_ld_ready", 64'(bus.ld_ready), 64'd0);
        check_val("full_alu_rd", 64'(bus.rd), 64'h105);
        // ALU idle: pop while full must not accept the offered 5th load
        bus.alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            bus.ld_valid = 1'b0;
            check_val("drain_we", 64'(bus.reg_we), 64'd1);
            check_val("drain_src", 64'(bus.rd_src), 64'(10 + j));
            check_val("drain_rd", 64'(bus.rd), 64'hA0 + 64'(j));
            check_val("drain_cnt", 64'(bus.fifo_cnt), 64'(3 - j));
        end
        cyc();
        check_val("drained_we", 64'(bus.reg_we), 64'd0);
        check_val("drained_cnt", 64'(bus.fifo_cnt), 64'd0);

        // 5: x0 issue and x0 load
        bus.iss_ld     = 1'b1;
        bus.iss_rd_src = 5'd0;
        cyc();
        bus.iss_ld = 1'b0;
        check_val("x0_iss_busy", 64'(bus.busy_mask), 64'd0);
        bus.ld_valid  = 1'b1;
        bus.ld_rd_src = 5'd0;
        bus.ld_data   = 32'h55;
        cyc();
        bus.ld_valid = 1'b0;
        check_val("x0_cnt_push", 64'(bus.fifo_cnt), 64'd1);
        cyc();
        check_val("x0_cnt_pop", 64'(bus.fifo_cnt), 64'd0);
        check_val("x0_we", 64'(bus.reg_we), 64'd0);
        check_val("x0_hold_src", 64'(bus.rd_src), 64'd13);
        check_val("x0_hold_rd", 64'(bus.rd), 64'hA3);

`ifdef WB_BYPASS_EN
        // 6: forwarding of the in-flight write
        bus.alu_valid  = 1'b1;
        bus.alu_rd_src = 5'd3;
        bus.alu_data   = 32'h42;
        cyc();
        bus.alu_valid = 1'b0;
        bus.rs1_src   = 5'd3;
        bus.rs1_in    = 32'd0;
        bus.rs2_src   = 5'd0;
        bus.rs2_in    = 32'h77;
        #1;
        check_val("fwd_rs1", 64'(bus.rs1_fwd), 64'h42);
        check_val("fwd_rs2_x0", 64'(bus.rs2_fwd), 64'h77);
        bus.rs1_src = 5'd4;
        bus.rs1_in  = 32'h5A;
        #1;
        check_val("fwd_rs1_miss", 64'(bus.rs1_fwd), 64'h5A);
`endif

        // mid-operation reset discards FIFO and pending bits
        bus.iss_ld     = 1'b1;
        bus.iss_rd_src = 5'd6;
        bus.ld_valid   = 1'b1;
        bus.ld_rd_src  = 5'd6;
        bus.ld_data    = 32'h66;
        bus.alu_valid  = 1'b1;
        bus.alu_rd_src = 5'd2;
        bus.alu_data   = 32'h22;
        cyc();
        bus.iss_ld   = 1'b0;
        bus.ld_valid = 1'b0;
        check_val("mid_cnt", 64'(bus.fifo_cnt), 64'd1);
        check_val("mid_busy", 64'(bus.busy_mask), 64'h40);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_cnt", 64'(bus.fifo_cnt), 64'd0);
        check_val("mid_rst_busy", 64'(bus.busy_mask), 64'd0);
        check_val("mid_rst_we", 64'(bus.reg_we), 64'd0);
        bus.alu_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check_val("post_rst_we", 64'(bus.reg_we), 64'd0);
        check_val("post_rst_cnt", 64'(bus.fifo_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_arbiter
